data_port_arbiter: RTL
======================

Name: data_port_arbiter

Overview:
- Two-master arbiter that sits directly upstream of the core data-memory controller (coremem).
- Merges the core LSU port (m0) and the debug/loader port (m1) onto the single req/gnt/rvalid slave port that coremem consumes.
- Round-robin fairness; exactly one transaction in flight, which matches the controller's single-outstanding behaviour.
- Routes each response back to the master that issued the request.

Parameters:
- ADDR_WIDTH, 32, address width of both masters and the slave.
- DATA_WIDTH, 32, write/read data width; byte-enable width is DATA_WIDTH/8.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- m0_req_i / m1_req_i  in  1  master request
- m0_we_i / m1_we_i  in  1  1 = write, 0 = read
- m0_be_i / m1_be_i  in  DATA_WIDTH/8  byte enables
- m0_addr_i / m1_addr_i  in  ADDR_WIDTH  address
- m0_wdata_i / m1_wdata_i  in  DATA_WIDTH  write data
- m0_gnt_o / m1_gnt_o  out  1  request accepted
- m0_rvalid_o / m1_rvalid_o  out  1  response valid
- m0_rdata_o / m1_rdata_o  out  DATA_WIDTH  read data
- s_req_o  out  1  slave request
- s_we_o  out  1  slave write enable
- s_be_o  out  DATA_WIDTH/8  slave byte enables
- s_addr_o  out  ADDR_WIDTH  slave address
- s_wdata_o  out  DATA_WIDTH  slave write data
- s_gnt_i  in  1  slave grant
- s_rvalid_i  in  1  slave response valid
- s_rdata_i  in  DATA_WIDTH  slave read data

Behaviour:
- Reset values:
  - state = IDLE; rr_q = 0, so m0 has priority first.
  - All gnt, rvalid and s_req_o outputs are 0.
  - s_we_o, s_be_o, s_addr_o and s_wdata_o are 0 whenever s_req_o = 0.
- Reset asserted mid-transaction: any pending response is abandoned; no rvalid is produced after reset releases.
- IDLE state:
  - If exactly one master requests, it wins. If both request, the master indexed by rr_q wins.
  - Winner selection is combinational: s_req_o and the winner's payload are driven in the same cycle (zero added latency).
  - s_gnt_i = 1 in the same cycle: pulse winner's gnt (mN_gnt_o = s_gnt_i & selected), latch owner_q = winner, rr_q <= ~winner, go to WAIT_RESP.
  - s_gnt_i = 0: latch owner_q = winner and go to HOLD.
- HOLD state:
  - Keep driving owner_q's request and payload; the other master is never switched in.
  - On s_gnt_i: pulse owner's gnt, set rr_q <= ~owner_q, go to WAIT_RESP.
  - A master must hold req and payload stable until gnt. The arbiter presents owner_q regardless of its current req value; a protocol assertion flags req dropping in HOLD.
- WAIT_RESP state:
  - s_req_o = 0; no grant is issued to either master.
  - On s_rvalid_i: drive owner_q's rvalid_o = 1 for that cycle, go to IDLE.
  - New requests are considered starting the cycle after rvalid.
- Read data: s_rdata_i is broadcast combinationally to both mN_rdata_o. rvalid goes only to the owner.
- Write responses also return through rvalid; rdata content is don't-care for writes.
- s_rvalid_i in IDLE or HOLD is ignored and flagged by assertion.
- Simultaneous requests: alternation is strict. With both masters requesting continuously, grants go m0, m1, m0, ...
- A single master requesting continuously is never blocked by rr_q.
- Throughput: at most one transaction per 3 cycles against coremem's read path; the arbiter adds no cycles beyond coremem.

Decomposition:
- Package data_port_pkg holds:
  - arb_state_e enum {IDLE, HOLD, WAIT_RESP} in 2 bits, default branch returning to IDLE.
  - master_idx_t (1-bit) type.
  - Constants M0 = 0, M1 = 1.
- Sub-module rr_arb2: combinational two-way round-robin picker.
  - Inputs: req[1:0], rr_q.
  - Outputs: valid, winner.
  - rr_q itself is registered in the parent.

Test Plan:
- Single read: m0 reads addr 0x100, slave gnt in the same cycle, rvalid 2 cycles later with rdata 0xDEADBEEF -> m0_gnt_o pulses in cycle 0; m0_rvalid_o = 1 with m0_rdata_o = 0xDEADBEEF; m1_rvalid_o stays 0.
- Contention: m0 and m1 both request continuously from reset -> grant order m0, m1, m0, m1; each rvalid goes only to the granted master.
- Delayed grant: m1 writes 0x55AA to 0x200 with be = 4'b0011, s_gnt_i held low 3 cycles; m0 raises req during the wait -> s_addr_o stays 0x200 throughout; m1 is granted first, m0 only after m1's rvalid.
- Response-phase block: m0 requests while WAIT_RESP is active for m1 -> m0_gnt_o = 0 until the cycle after m1_rvalid_o, then m0 is served.
- Reset mid-transaction: rst_ni asserted in WAIT_RESP -> all outputs are 0 immediately; after release, a stray s_rvalid_i produces no mN_rvalid_o.
- Back-to-back singles: m1-only requests for 4 consecutive transactions -> all 4 are granted to m1 with no idle gap beyond the slave's response latency.

Source files
------------

// File: rtl/data_port_pkg.sv
// Shared types for the two-master data-port arbiter in front of coremem.
package data_port_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD      = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_e;

  typedef logic master_idx_t;

  localparam master_idx_t M0 = 1'b0;
  localparam master_idx_t M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker; rr_i names the master preferred on a tie.
module rr_arb2
  import data_port_pkg::*;
(
  input  logic [1:0]  req_i,
  input  master_idx_t rr_i,
  output logic        valid_o,
  output master_idx_t winner_o
);

  always_comb begin
    valid_o = |req_i;
    case (req_i)
      2'b01:   winner_o = M0;
      2'b10:   winner_o = M1;
      2'b11:   winner_o = rr_i;
      default: winner_o = M0;
    endcase
  end

endmodule

// File: rtl/data_port_arbiter.sv
// Merges the LSU (m0) and debug/loader (m1) ports onto coremem's single-outstanding
// req/gnt/rvalid port, round-robin on ties, with responses routed to the issuing master.
module data_port_arbiter
  import data_port_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    m0_req_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_gnt_o,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_req_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_gnt_o,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    s_req_o,
  output logic                    s_we_o,
  output logic [DATA_WIDTH/8-1:0] s_be_o,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  input  logic                    s_gnt_i,
  input  logic                    s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   s_rdata_i
);

  arb_state_e  state_q, state_d;
  master_idx_t owner_q, owner_d;
  master_idx_t rr_q, rr_d;

  logic        arb_valid;
  master_idx_t arb_winner;
  logic        sel_valid;
  master_idx_t sel;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;

  rr_arb2 u_rr_arb2 (
    .req_i    ({m1_req_i, m0_req_i}),
    .rr_i     (rr_q),
    .valid_o  (arb_valid),
    .winner_o (arb_winner)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    sel_valid = 1'b0;
    sel       = owner_q;
    gnt       = 2'b00;
    rvalid    = 2'b00;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          sel_valid = 1'b1;
          sel       = arb_winner;
          owner_d   = arb_winner;
          if (s_gnt_i) begin
            gnt[arb_winner] = 1'b1;
            rr_d            = ~arb_winner;
            state_d         = WAIT_RESP;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // Owner stays presented even if its req drops; the other master waits.
        sel_valid = 1'b1;
        if (s_gnt_i) begin
          gnt[owner_q] = 1'b1;
          rr_d         = ~owner_q;
          state_d      = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (s_rvalid_i) begin
          rvalid[owner_q] = 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Payload is forced to zero whenever no request is presented to coremem.
  always_comb begin
    s_req_o   = 1'b0;
    s_we_o    = 1'b0;
    s_be_o    = '0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    if (sel_valid) begin
      s_req_o = 1'b1;
      if (sel == M1) begin
        s_we_o    = m1_we_i;
        s_be_o    = m1_be_i;
        s_addr_o  = m1_addr_i;
        s_wdata_o = m1_wdata_i;
      end else begin
        s_we_o    = m0_we_i;
        s_be_o    = m0_be_i;
        s_addr_o  = m0_addr_i;
        s_wdata_o = m0_wdata_i;
      end
    end
  end

  assign m0_gnt_o    = gnt[M0];
  assign m1_gnt_o    = gnt[M1];
  assign m0_rvalid_o = rvalid[M0];
  assign m1_rvalid_o = rvalid[M1];
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= M0;
      rr_q    <= M0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      if (state_q != WAIT_RESP) begin
        assert (!s_rvalid_i)
          else $warning("s_rvalid_i ignored outside WAIT_RESP");
      end
      if (state_q == HOLD) begin
        assert ((owner_q == M1) ? m1_req_i : m0_req_i)
          else $warning("owner dropped req before gnt");
      end
    end
  end
`endif

endmodule
